mem_lsu: RTL
============

# mem_lsu

Parametrised load/store unit for the MEM stage, replacing the fixed single-cycle 32-bit data-SRAM path. Accepts one memory op per handshake, drives an SRAM-like request/address-ok/data-ok bus with multi-cycle latency, and performs byte-lane alignment on both directions. Detects misaligned accesses, absorbs pipeline flushes safely, and returns a register-file writeback or exception result to WB.

## Interface
- DATA_W, 32, data path width; 32 or 64.
- ADDR_W, 32, byte-address width.
- RF_AW, 5, register-file address width.

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  cancel the in-flight op (exception or eret in CP0)
- in_valid  in  1  op presented
- in_ready  out  1  unit can accept; equals state==IDLE
- in_store  in  1  1 = store, 0 = load
- in_size  in  2  0 byte, 1 half, 2 word, 3 dword
- in_signed  in  1  sign-extend load result
- in_addr  in  ADDR_W  byte address
- in_wdata  in  DATA_W  store data, right-aligned
- in_rf_waddr  in  RF_AW  load destination
- data_req  out  1  bus request
- data_wr  out  1  write request
- data_size  out  2  copy of latched size
- data_addr  out  ADDR_W  latched address
- data_wstrb  out  DATA_W/8  byte enables
- data_wdata  out  DATA_W  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response or write done
- data_rdata  in  DATA_W  read data
- out_valid  out  1  one-cycle result pulse
- out_rf_we  out  1  register write enable; load with no exception
- out_rf_waddr  out  RF_AW  destination
- out_rf_wdata  out  DATA_W  extended load data
- out_adel  out  1  misaligned load
- out_ades  out  1  misaligned store
- out_badvaddr  out  ADDR_W  faulting address
- stall_req  out  1  requests a pipeline stall; equals in_valid & ~in_ready

## Operation
- States: IDLE, REQ, WAIT, CANCEL, DONE.
- Accept condition: in_valid & in_ready & ~flush. All inputs are latched on accept.
- Legal sizes: in_size=3 with DATA_W=32 is treated as size 2.
- Misalignment rule: addr[size-1:0] != 0.
  - Misaligned op goes IDLE->DONE and issues no bus request.
  - out_adel or out_ades is set; out_badvaddr = addr.
  - out_rf_we = 0.
- Aligned op goes IDLE->REQ.
- REQ: data_req=1; all data_* outputs are held stable.
  - addr_ok & data_ok together -> DONE.
  - addr_ok alone -> WAIT.
- WAIT: data_req=0; data_ok -> DONE, capturing data_rdata.
- DONE: out_valid=1 for exactly one cycle, then -> IDLE.
- Lane index: lane = addr[log2(DATA_W/8)-1:0].
- Store path:
  - wstrb = ((1<<(1<<size))-1) << lane.
  - wdata = in_wdata low (8<<size) bits replicated across DATA_W.
- Load path:
  - shifted = rdata >> (lane*8).
  - Shifted value is truncated to 8<<size bits, then sign- or zero-extended to DATA_W.
  - Store ops return out_rf_we=0.
- Flush handling:
  - IDLE: the op is not accepted.
  - REQ before addr_ok: next state IDLE, data_req drops next cycle.
  - REQ with addr_ok, or in WAIT: -> CANCEL; CANCEL waits for data_ok, discards it, then -> IDLE. No out_valid.
  - DONE: out_valid is suppressed that cycle.
- Output fields other than out_valid are don't-care when out_valid=0; they are driven 0.

## Timing
- Reset values: state IDLE, in_ready=1, data_req=0, data_wr=0, data_wstrb=0, out_valid=0, all out_* fields 0.
- Latency, accept at cycle T:
  - data_req is high from T+1.
  - With addr_ok at T+1 and data_ok at T+2, out_valid is at T+3.
  - Minimum latency, addr_ok and data_ok both at T+1: out_valid at T+2.
  - Misaligned op: out_valid at T+1.
- Throughput: one op per (latency+1) cycles. in_ready is low from T+1 until the cycle after DONE.
- data_ok arriving in IDLE or REQ without a prior addr_ok is ignored.
- Asserting rst mid-transaction clears state immediately. The SRAM side must be reset together.

## Test plan
- Aligned lw, DATA_W=32, addr 0x1000, rdata 0xDEADBEEF, addr_ok at T+1, data_ok at T+3 -> out_valid at T+4 only, wdata 0xDEADBEEF, rf_we=1.
- lb signed at addr 0x1003, rdata 0x80112233 -> wdata 0xFFFFFF80.
- Same op as lbu -> wdata 0x00000080.
- sh at addr 0x1002, in_wdata 0x0000ABCD -> data_wstrb 4'b1100, data_wdata 0xABCDABCD, out_rf_we=0.
- lw at addr 0x1006 -> no data_req, out_valid at T+1, out_adel=1, out_badvaddr 0x1006.
- sh at addr 0x1001 -> out_ades=1.
- Flush in REQ with addr_ok=0 -> data_req low the next cycle, no out_valid.
- Flush in WAIT -> CANCEL; data_ok 2 cycles later is discarded; in_ready returns the following cycle.
- DATA_W=64, ld at addr 0x2008 -> wstrb/lane logic selects the full word.
- DATA_W=64, lw signed at 0x2004, rdata 0x8000000100000000 -> wdata 0xFFFFFFFF80000001.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving an SRAM-like req/addr_ok/data_ok bus.
// Aligns store lanes, extends load data, raises misalignment exceptions, absorbs flushes.
module mem_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RF_AW  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_store,
  input  logic [1:0]          in_size,
  input  logic                in_signed,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [RF_AW-1:0]    in_rf_waddr,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata,
  output logic                out_valid,
  output logic                out_rf_we,
  output logic [RF_AW-1:0]    out_rf_waddr,
  output logic [DATA_W-1:0]   out_rf_wdata,
  output logic                out_adel,
  output logic                out_ades,
  output logic [ADDR_W-1:0]   out_badvaddr,
  output logic                stall_req
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CANCEL = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              store_q, signed_q, mis_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [RF_AW-1:0]  rf_waddr_q;

  logic              accept, capture, in_mis;
  logic [1:0]        in_size_eff;
  logic [LANE_W-1:0] lane;
  logic [3:0]        n_bytes;
  logic [NB-1:0]     strb;
  logic [DATA_W-1:0] wrep, shifted, left, ld_ext;
  logic [6:0]        ext_sh;

  // A 32-bit datapath has no dword access; fold it onto a word.
  assign in_size_eff = (DATA_W == 32 && in_size == 2'd3) ? 2'd2 : in_size;
  assign accept      = in_valid & in_ready & ~flush;

  always_comb begin
    case (in_size_eff)
      2'd0:    in_mis = 1'b0;
      2'd1:    in_mis = in_addr[0];
      2'd2:    in_mis = |in_addr[1:0];
      default: in_mis = |in_addr[2:0];
    endcase
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = in_mis ? S_DONE : S_REQ;
      S_REQ: begin
        if (data_addr_ok) begin
          if (flush)             state_d = data_data_ok ? S_IDLE : S_CANCEL;
          else if (data_data_ok) begin state_d = S_DONE; capture = 1'b1; end
          else                   state_d = S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush)             state_d = data_data_ok ? S_IDLE : S_CANCEL;
        else if (data_data_ok) begin state_d = S_DONE; capture = 1'b1; end
      end
      // An accepted request must still have its response drained before reuse.
      S_CANCEL: if (data_data_ok) state_d = S_IDLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      store_q    <= 1'b0;
      signed_q   <= 1'b0;
      mis_q      <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rf_waddr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (accept) begin
        store_q    <= in_store;
        signed_q   <= in_signed;
        mis_q      <= in_mis;
        size_q     <= in_size_eff;
        addr_q     <= in_addr;
        wdata_q    <= in_wdata;
        rf_waddr_q <= in_rf_waddr;
      end
      if (capture) rdata_q <= data_rdata;
    end
  end

  assign lane    = addr_q[LANE_W-1:0];
  assign n_bytes = 4'd1 << size_q;
  assign strb    = NB'((16'd1 << n_bytes) - 16'd1) << lane;

  always_comb begin
    case (size_q)
      2'd0:    wrep = {NB{wdata_q[7:0]}};
      2'd1:    wrep = {(NB/2){wdata_q[15:0]}};
      2'd2:    wrep = {(NB/4){wdata_q[31:0]}};
      default: wrep = wdata_q;
    endcase
  end

  // Load extension: push the access's top bit to the MSB, then shift back down.
  always_comb begin
    shifted = rdata_q >> {lane, 3'b000};
    case (size_q)
      2'd0:    ext_sh = 7'(DATA_W - 8);
      2'd1:    ext_sh = 7'(DATA_W - 16);
      2'd2:    ext_sh = 7'(DATA_W - 32);
      default: ext_sh = 7'd0;
    endcase
    left = shifted << ext_sh;
    if (signed_q) ld_ext = $signed(left) >>> ext_sh;
    else          ld_ext = left >> ext_sh;
  end

  assign in_ready   = (state_q == S_IDLE);
  assign stall_req  = in_valid & ~in_ready;

  assign data_req   = (state_q == S_REQ);
  assign data_wr    = data_req & store_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wstrb = data_req ? strb : '0;
  assign data_wdata = wrep;

  assign out_valid    = (state_q == S_DONE) & ~flush;
  assign out_rf_we    = out_valid & ~store_q & ~mis_q;
  assign out_rf_waddr = out_valid ? rf_waddr_q : '0;
  assign out_rf_wdata = out_rf_we ? ld_ext : '0;
  assign out_adel     = out_valid & mis_q & ~store_q;
  assign out_ades     = out_valid & mis_q & store_q;
  assign out_badvaddr = (out_valid & mis_q) ? addr_q : '0;

endmodule
